// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the host-side writer, the transmit FIFO and the
// UART transmitter launch path. The FIFO attaches through the slave modport.
interface uart_tx_fifo_if #(
    parameter int NB_DATA = 8,
    parameter int DEPTH   = 16
);
    localparam int NB_PTR = $clog2(DEPTH);

    logic               i_wr;
    logic [NB_DATA-1:0] i_wr_data;
    logic               i_clr_ovf;
    logic               i_txdone;
    logic               o_start_tx;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_full;
    logic               o_empty;
    logic [NB_PTR:0]    o_count;
    logic               o_busy;
    logic               o_overflow;

    modport master (
        output i_wr, i_wr_data, i_clr_ovf, i_txdone,
        input  o_start_tx, o_tx_data, o_full, o_empty, o_count, o_busy, o_overflow
    );

    modport slave (
        input  i_wr, i_wr_data, i_clr_ovf, i_txdone,
        output o_start_tx, o_tx_data, o_full, o_empty, o_count, o_busy, o_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO plus a three-state launch controller that hands one
// byte at a time to the UART transmitter and waits for its done pulse.
module uart_tx_fifo #(
    parameter int NB_DATA = 8,
    parameter int DEPTH   = 16
) (
    input  logic            clk,
    input  logic            i_rst_n,
    uart_tx_fifo_if.slave   bus
);
    localparam int NB_PTR = $clog2(DEPTH);
    localparam logic [NB_PTR:0] FULL_COUNT = (NB_PTR+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        LAUNCH    = 3'b010,
        WAIT_DONE = 3'b100
    } state_t;

    state_t             state;
    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_PTR-1:0]  wr_ptr;
    logic [NB_PTR-1:0]  rd_ptr;
    logic [NB_PTR:0]    count;
    logic [NB_DATA-1:0] tx_data;
    logic               overflow;

    logic full;
    logic wr_accept;
    logic pop;

    // Full is judged on the registered count, so a pop in the same cycle
    // never rescues a write attempted while full.
    assign full      = (count == FULL_COUNT);
    assign wr_accept = bus.i_wr && !full;
    assign pop       = (state == IDLE) && (count != '0);

    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= bus.i_wr_data;
        end
    end

    // NOTE: every register is updated with <= so all state advances together
    // on the edge regardless of statement order.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            unique case ({wr_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A new overflow beats a simultaneous clear.
            if (bus.i_wr && full) begin
                overflow <= 1'b1;
            end else if (bus.i_clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.i_txdone) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Start pulse is a pure state decode, so it lasts exactly one cycle.
    assign bus.o_start_tx = (state == LAUNCH);
    assign bus.o_busy     = (state != IDLE);
    assign bus.o_tx_data  = tx_data;
    assign bus.o_full     = full;
    assign bus.o_empty    = (count == '0);
    assign bus.o_count    = count;
    assign bus.o_overflow = overflow;
endmodule
